// File: rtl/md_wb_pkg.sv
// Shared widths, packet layouts and the cell-to-node mapping for the force writeback router.
package md_wb_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int CELL_ID_WIDTH     = 3;
  localparam int PARTICLE_ID_WIDTH = 7;
  localparam int NUM_CELL_X        = 3;
  localparam int NUM_CELL_Y        = 3;
  localparam int NUM_CELL_Z        = 3;
  localparam int NUM_NODES         = NUM_CELL_X * NUM_CELL_Y * NUM_CELL_Z;
  localparam int NODE_ID_WIDTH     = $clog2(NUM_NODES);
  localparam int ID_WIDTH          = 3 * CELL_ID_WIDTH + PARTICLE_ID_WIDTH;
  localparam int WB_WIDTH          = ID_WIDTH + 3 * DATA_WIDTH;
  localparam int NET_WIDTH         = NODE_ID_WIDTH + WB_WIDTH;

  typedef logic [CELL_ID_WIDTH-1:0]     cell_coord_t;
  typedef logic [NODE_ID_WIDTH-1:0]     node_id_t;
  typedef logic [PARTICLE_ID_WIDTH-1:0] pid_t;
  typedef logic [DATA_WIDTH-1:0]        force_t;

  // Writeback packet exactly as the distributor emits it.
  typedef struct packed {
    cell_coord_t cell_x;
    cell_coord_t cell_y;
    cell_coord_t cell_z;
    pid_t        pid;
    force_t      fz;
    force_t      fy;
    force_t      fx;
  } wb_pkt_t;

  // Packet offered to the ring: destination node prepended to the untouched writeback.
  typedef struct packed {
    node_id_t dest_node;
    wb_pkt_t  pkt;
  } net_pkt_t;

  // Coordinates are 1-based; 0 or anything beyond the grid is illegal.
  function automatic logic coord_ok(cell_coord_t c, int num_cells);
    return (c != '0) && (int'(c) <= num_cells);
  endfunction

  function automatic logic cell_ok(cell_coord_t cx, cell_coord_t cy, cell_coord_t cz);
    return coord_ok(cx, NUM_CELL_X) && coord_ok(cy, NUM_CELL_Y) && coord_ok(cz, NUM_CELL_Z);
  endfunction

  // Row-major linearisation of the 1-based cell coordinate, done at node-id width.
  function automatic node_id_t cell_to_node(cell_coord_t cx, cell_coord_t cy, cell_coord_t cz);
    node_id_t nx;
    node_id_t ny;
    node_id_t nz;
    nx = node_id_t'(cx) - node_id_t'(1);
    ny = node_id_t'(cy) - node_id_t'(1);
    nz = node_id_t'(cz) - node_id_t'(1);
    return nx * node_id_t'(NUM_CELL_Y * NUM_CELL_Z) + ny * node_id_t'(NUM_CELL_Z) + nz;
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is read straight from the
// storage registers and almost_full is a registered "SKID or fewer free entries" flag.
module wb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int SKID  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - SKID);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_next;
  logic [AW:0]      rd_ptr_next;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Pop is resolved first, so a push into a full FIFO that is popping the same cycle still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero while empty so a flushed FIFO never shows stale data.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Next pointers and the occupancy they imply, used for the registered almost-full flag.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, otherwise a latch is inferred.
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (do_push) wr_ptr_next = wr_ptr + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_next = rd_ptr + {{AW{1'b0}}, 1'b1};
    count_next = wr_ptr_next - rd_ptr_next;
  end

  // Pointer and flag state; almost_full reads 1 in reset so the upstream sees "not ready".
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      almost_full <= 1'b1;
    end else begin
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      almost_full <= (count_next >= AF_LEVEL);
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers alone define which words are valid.
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/force_wb_router.sv
// Force writeback router: captures distributor writebacks, sends home-cell forces to the
// local force cache and queues remote packets, tagged with their node id, for the ring.
module force_wb_router
  import md_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SKID       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3*CELL_ID_WIDTH-1:0]    home_cell_id,
  input  logic [WB_WIDTH-1:0]           wb_in,
  input  logic                          wb_in_valid,
  output logic                          ready_out,
  output logic                          local_wr_valid,
  output logic [PARTICLE_ID_WIDTH-1:0]  local_wr_pid,
  output logic [3*DATA_WIDTH-1:0]       local_wr_force,
  output logic                          net_valid,
  output logic [NET_WIDTH-1:0]          net_data,
  input  logic                          net_ready,
  output logic                          overflow_err
);

  wb_pkt_t  in_pkt;
  logic     in_ok;
  logic     in_local;
  logic     s1_valid;
  net_pkt_t s1_pkt;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_almost_full;
  logic     push_drop;

  assign in_pkt   = wb_pkt_t'(wb_in);
  assign in_ok    = cell_ok(in_pkt.cell_x, in_pkt.cell_y, in_pkt.cell_z);
  assign in_local = ({in_pkt.cell_x, in_pkt.cell_y, in_pkt.cell_z} == home_cell_id);

  // A remote packet is lost only if the FIFO is full and nothing leaves it this cycle.
  assign push_drop = s1_valid && fifo_full && !net_ready;

  // Control registers: local write strobe, remote stage-1 valid and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      local_wr_valid <= 1'b0;
      local_wr_pid   <= '0;
      local_wr_force <= '0;
      s1_valid       <= 1'b0;
      overflow_err   <= 1'b0;
    end else begin
      local_wr_valid <= wb_in_valid && in_ok && in_local;
      s1_valid       <= wb_in_valid && in_ok && !in_local;
      if (wb_in_valid && in_ok && in_local) begin
        local_wr_pid   <= in_pkt.pid;
        local_wr_force <= {in_pkt.fz, in_pkt.fy, in_pkt.fx};
      end
      if (push_drop || (wb_in_valid && !in_ok)) overflow_err <= 1'b1;
    end
  end

  // Stage-1 datapath register for remote packets, tagged with the destination node.
  always_ff @(posedge clk) begin
    if (wb_in_valid) begin
      s1_pkt <= '{dest_node: cell_to_node(in_pkt.cell_x, in_pkt.cell_y, in_pkt.cell_z),
                  pkt:       in_pkt};
    end
  end

  wb_sync_fifo #(
    .WIDTH (NET_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .SKID  (SKID)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (s1_valid),
    .din         (s1_pkt),
    .pop         (net_ready),
    .dout        (net_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .almost_full (fifo_almost_full)
  );

  assign net_valid = !fifo_empty;
  assign ready_out = !fifo_almost_full;

endmodule
